// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler in front of one shared ALU.
// Two requesters compete for the ALU. The winner's ctrl and operands are
// registered onto the ALU inputs and held for a per-opcode number of cycles,
// so that mul/div can be multicycle paths. The result is then captured and
// returned over a valid/ready response port. One operation is in flight at a time.
module alu_sched #(
    parameter int Width  = 32,
    parameter int MulLat = 3,
    parameter int DivLat = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [7:0]         req_ctrl,
    input  logic [2*Width-1:0] req_op1,
    input  logic [2*Width-1:0] req_op2,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [Width-1:0]   rsp_data,
    output logic               rsp_carry,
    output logic               rsp_zero,
    output logic [3:0]         alu_ctrl,
    output logic [Width-1:0]   alu_op1,
    output logic [Width-1:0]   alu_op2,
    input  logic [Width-1:0]   alu_out,
    input  logic               alu_carry,
    input  logic               alu_zero
);

    localparam int MaxLat = (MulLat > DivLat) ? MulLat : DivLat;
    localparam int CntW   = $clog2(MaxLat + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic              prio_reg, prio_next;
    logic [CntW-1:0]   cnt_reg, cnt_next;

    logic [3:0]        alu_ctrl_reg;
    logic [Width-1:0]  alu_op1_reg, alu_op2_reg;
    logic              rsp_id_reg;
    logic [Width-1:0]  rsp_data_reg;
    logic              rsp_carry_reg, rsp_zero_reg;

    logic              grant_any;
    logic              grant_id;
    logic              accept;
    logic              capture;

    logic [3:0]        ctrl_arr [2];
    logic [Width-1:0]  op1_arr  [2];
    logic [Width-1:0]  op2_arr  [2];

    // Unpack the flat per-requester buses and form the per-requester ready.
    // Ready is held low while reset is asserted so no handshake is seen then.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign ctrl_arr[gi] = req_ctrl[4*gi +: 4];
            assign op1_arr[gi]  = req_op1[Width*gi +: Width];
            assign op2_arr[gi]  = req_op2[Width*gi +: Width];
            assign req_ready[gi] = (state_reg == IDLE) && !rst && grant_any
                                   && (grant_id == 1'(gi));
        end
    endgenerate

    // Execute cycles minus one for a ctrl code; every non mul/div code,
    // including the undefined ones, takes a single cycle.
    function automatic logic [CntW-1:0] lat_m1(input logic [3:0] c);
        case (c)
            4'b0110: return CntW'(MulLat - 1);
            4'b0111: return CntW'(DivLat - 1);
            default: return '0;
        endcase
    endfunction

    // Whether the ALU drives a meaningful carry for this ctrl code.
    // Logic ops, 1000 and the undefined codes leave carry undriven, so the
    // captured carry is forced to zero for them.
    function automatic logic carry_kept(input logic [3:0] c);
        case (c)
            4'b0100, 4'b0101, 4'b0110, 4'b0111,
            4'b1001, 4'b1010: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    // Round-robin grant: the priority holder wins if valid, otherwise the other requester.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = prio_reg;
        if (req_valid[prio_reg]) begin
            grant_any = 1'b1;
            grant_id  = prio_reg;
        end else if (req_valid[~prio_reg]) begin
            grant_any = 1'b1;
            grant_id  = ~prio_reg;
        end
    end

    // Next-state logic, latency counter and the accept/capture strobes.
    always_comb begin
        state_next = state_reg;
        prio_next  = prio_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                    cnt_next   = lat_m1(ctrl_arr[grant_id]);
                    prio_next  = ~grant_id;
                end
            end
            EXEC: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CntW'(1);
                end else begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, priority and latency counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            prio_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            prio_reg  <= prio_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ALU input registers: loaded only on an acceptance, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_ctrl_reg <= 4'd0;
            alu_op1_reg  <= '0;
            alu_op2_reg  <= '0;
            rsp_id_reg   <= 1'b0;
        end else if (accept) begin
            alu_ctrl_reg <= ctrl_arr[grant_id];
            alu_op1_reg  <= op1_arr[grant_id];
            alu_op2_reg  <= op2_arr[grant_id];
            rsp_id_reg   <= grant_id;
        end
    end

    // Result registers: capture the ALU output on the last execute cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data_reg  <= '0;
            rsp_carry_reg <= 1'b0;
            rsp_zero_reg  <= 1'b0;
        end else if (capture) begin
            rsp_data_reg  <= alu_out;
            rsp_zero_reg  <= alu_zero;
            rsp_carry_reg <= alu_carry & carry_kept(alu_ctrl_reg);
        end
    end

    assign rsp_valid = (state_reg == RESP);
    assign rsp_id    = rsp_id_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_carry = rsp_carry_reg;
    assign rsp_zero  = rsp_zero_reg;
    assign alu_ctrl  = alu_ctrl_reg;
    assign alu_op1   = alu_op1_reg;
    assign alu_op2   = alu_op2_reg;

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: self-checking bench for alu_sched with a behavioural ALU.
// The stand-in ALU drives carry high for codes that have no real carry, so
// that the scheduler's carry masking is visible.
module tb_alu_sched;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [7:0]    req_ctrl;
    logic [2*W-1:0] req_op1, req_op2;
    logic          rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0]  rsp_data;
    logic          rsp_carry, rsp_zero;
    logic [3:0]    alu_ctrl;
    logic [W-1:0]  alu_op1, alu_op2, alu_out;
    logic          alu_carry, alu_zero;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic         id;
        logic [W-1:0] data;
        logic         carry;
        logic         zero;
    } exp_t;

    typedef struct {
        int           id;
        logic [3:0]   ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] data;
        logic         carry;
        logic         zero;
        int           lat;
    } vec_t;

    exp_t sb[$];
    logic gl[$];
    exp_t e_mon;
    vec_t vt[10];

    always #5 clk = ~clk;

    alu_sched #(.Width(W), .MulLat(3), .DivLat(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl),
        .req_op1(req_op1), .req_op2(req_op2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .alu_ctrl(alu_ctrl), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero)
    );

    // Behavioural ALU attached to the scheduler's registered outputs.
    logic [W:0]     wide;
    logic [2*W-1:0] prod;
    always_comb begin
        alu_out   = '0;
        alu_carry = 1'b1;
        wide      = {1'b0, alu_op1} + {1'b0, alu_op2};
        prod      = {32'd0, alu_op1} * {32'd0, alu_op2};
        case (alu_ctrl)
            4'b0001: alu_out = alu_op1 & alu_op2;
            4'b0010: alu_out = alu_op1 | alu_op2;
            4'b0100: begin alu_out = wide[W-1:0]; alu_carry = wide[W]; end
            4'b0101: begin alu_out = alu_op1 - alu_op2; alu_carry = (alu_op1 < alu_op2); end
            4'b0110: begin alu_out = prod[W-1:0]; alu_carry = |prod[2*W-1:W]; end
            4'b0111: begin
                alu_out   = (alu_op2 != 0) ? alu_op1 / alu_op2 : '1;
                alu_carry = (alu_op2 == 0);
            end
            4'b1000: alu_out = alu_op1 ^ alu_op2;
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == '0);
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: grant log and response comparison at each handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if ((req_valid & req_ready) != 2'b00) gl.push_back(req_ready[1]);
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got response id=%0d data=%h, expected none", rsp_id, rsp_data);
                end else begin
                    e_mon = sb.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e_mon.id));
                    check("rsp_data", rsp_data, e_mon.data);
                    check("rsp_carry", 32'(rsp_carry), 32'(e_mon.carry));
                    check("rsp_zero", 32'(rsp_zero), 32'(e_mon.zero));
                    $display("[TB] rsp id=%0d data=%h carry=%0d zero=%0d", rsp_id, rsp_data, rsp_carry, rsp_zero);
                end
            end
        end
    end

    // Raise a request, wait (bounded) for its grant, push the expected result.
    task automatic issue(input int id, input logic [3:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] ed,
                         input logic ec, input logic ez);
        exp_t e;
        int   waited;
        bit   ok;
        req_ctrl[4*id +: 4] = c;
        req_op1[W*id +: W]  = a;
        req_op2[W*id +: W]  = b;
        req_valid[id]       = 1'b1;
        waited = 0;
        ok     = 1'b0;
        while (!ok && waited < 200) begin
            @(negedge clk);
            if (req_ready[id]) ok = 1'b1;
            else waited++;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: requester %0d got no grant, expected one", id);
        end else begin
            e.id = 1'(id); e.data = ed; e.carry = ec; e.zero = ez;
            sb.push_back(e);
            $display("[TB] req id=%0d ctrl=%b a=%h b=%h", id, c, a, b);
        end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        gl.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
        check({tag, "_rsp_data"},  rsp_data,       32'd0);
        check({tag, "_rsp_carry"}, 32'(rsp_carry), 32'd0);
        check({tag, "_rsp_zero"},  32'(rsp_zero),  32'd0);
        check({tag, "_alu_ctrl"},  32'(alu_ctrl),  32'd0);
        check({tag, "_alu_op1"},   alu_op1,        32'd0);
        check({tag, "_alu_op2"},   alu_op2,        32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  stable;
        int  k;

        vt[0] = '{0, 4'b0100, 32'hFFFF_FFFF, 32'h1,    32'h0,         1'b1, 1'b1, 1};
        vt[1] = '{1, 4'b0111, 32'd100,       32'd7,    32'd14,        1'b0, 1'b0, 8};
        vt[2] = '{0, 4'b0110, 32'd6,         32'd7,    32'd42,        1'b0, 1'b0, 3};
        vt[3] = '{0, 4'b1111, 32'h1234,      32'h5678, 32'h0,         1'b0, 1'b1, 1};
        vt[4] = '{1, 4'b0101, 32'd5,         32'd3,    32'd2,         1'b0, 1'b0, 1};
        vt[5] = '{1, 4'b0001, 32'hF0F0,      32'h0FF0, 32'h00F0,      1'b0, 1'b0, 1};
        vt[6] = '{0, 4'b0100, 32'd7,         32'd8,    32'd15,        1'b0, 1'b0, 1};
        vt[7] = '{1, 4'b0110, 32'h10000,     32'h10000, 32'h0,        1'b1, 1'b1, 3};
        vt[8] = '{0, 4'b1000, 32'hFF,        32'h0F,   32'hF0,        1'b0, 1'b0, 1};
        vt[9] = '{1, 4'b0101, 32'd3,         32'd5,    32'hFFFF_FFFE, 1'b1, 1'b0, 1};

        req_valid = 2'b00;
        req_ctrl  = '0;
        req_op1   = '0;
        req_op2   = '0;
        rsp_ready = 1'b1;

        // Reset state
        do_reset();
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;

        // Single-requester vectors: latency, operand hold, result via scoreboard
        for (int i = 0; i < 10; i++) begin
            rsp_ready = 1'b1;
            issue(vt[i].id, vt[i].ctrl, vt[i].a, vt[i].b, vt[i].data, vt[i].carry, vt[i].zero);
            cyc    = 0;
            stable = 1'b1;
            while (cyc < 50) begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
                if (alu_ctrl !== vt[i].ctrl || alu_op1 !== vt[i].a || alu_op2 !== vt[i].b)
                    stable = 1'b0;
                if (rsp_valid) break;
            end
            check("latency", 32'(cyc), 32'(vt[i].lat));
            check("operand_hold", 32'(stable), 32'd1);
            wait_drain();
        end

        // Both requesters continuously valid: grants alternate 0,1,0,1
        do_reset();
        rsp_ready = 1'b1;
        fork
            begin
                issue(0, 4'b0001, 32'hF0F0, 32'h0FF0, 32'h00F0, 1'b0, 1'b0);
                issue(0, 4'b0001, 32'hF0F0, 32'h0FF0, 32'h00F0, 1'b0, 1'b0);
            end
            begin
                issue(1, 4'b0010, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0);
                issue(1, 4'b0010, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0);
            end
        join
        wait_drain();
        check("grant_count", 32'(gl.size()), 32'd4);
        for (k = 0; k < 4 && k < gl.size(); k++)
            check("grant_order", 32'(gl[k]), 32'(k % 2));

        // Backpressure on a mul with requester 1 waiting
        rsp_ready = 1'b0;
        issue(0, 4'b0110, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0);
        req_ctrl[7:4]   = 4'b0010;
        req_op1[63:32]  = 32'h1;
        req_op2[63:32]  = 32'h2;
        req_valid[1]    = 1'b1;
        cyc = 0;
        while (cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) break;
        end
        check("bp_valid_seen", 32'(rsp_valid), 32'd1);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("bp_valid_held", 32'(rsp_valid), 32'd1);
            check("bp_data_held", rsp_data, 32'd42);
            check("bp_no_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_no_ready_hs", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("bp_ready_after_hs", 32'(req_ready), 32'd2);
        if (req_ready[1]) begin
            e_mon.id = 1'b1; e_mon.data = 32'h3; e_mon.carry = 1'b0; e_mon.zero = 1'b0;
            sb.push_back(e_mon);
        end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_drain();

        // Reset on the 3rd EXEC cycle of a div abandons it
        rsp_ready = 1'b1;
        issue(1, 4'b0111, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        issue(0, 4'b0101, 32'd5, 32'd3, 32'd2, 1'b0, 1'b0);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
